// File: rtl/intr_controller_pkg.sv
// Shared definitions for the interrupt sequencer: default sizing, the
// location of the ISR vector in unified memory, and the FSM state encoding.
package intr_controller_pkg;

    localparam int DEFAULT_ADDR_W       = 8;
    localparam int DEFAULT_DRAIN_CYCLES = 3;

    // The memory side decodes vec_rd as a read of this address.
    localparam logic [7:0] VECTOR_ADDR = 8'h01;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRAIN   = 3'd1;
    localparam logic [2:0] ST_SAVE    = 3'd2;
    localparam logic [2:0] ST_VECTOR  = 3'd3;
    localparam logic [2:0] ST_ENTER   = 3'd4;
    localparam logic [2:0] ST_ACTIVE  = 3'd5;
    localparam logic [2:0] ST_RESTORE = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        DRAIN   = ST_DRAIN,
        SAVE    = ST_SAVE,
        VECTOR  = ST_VECTOR,
        ENTER   = ST_ENTER,
        ACTIVE  = ST_ACTIVE,
        RESTORE = ST_RESTORE
    } state_t;

endpackage

// File: rtl/intr_controller.sv
// Interrupt sequencer beside the decode stage. Catches a rising edge on the
// interrupt pin, waits for an instruction boundary, drains the pipeline,
// saves PC and flags, fetches the ISR address from the vector slot and
// redirects fetch. Further service is masked until RTI retires.
module intr_controller
    import intr_controller_pkg::*;
#(
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt,
    input  logic              pipe_busy,
    input  logic [ADDR_W-1:0] pc_F,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [7:0]        mem_rdata,
    input  logic              rti_retire,
    output logic              stall_F,
    output logic              flush_D,
    output logic              push_pc,
    output logic [ADDR_W-1:0] save_pc,
    output logic              save_flags,
    output logic              restore_flags,
    output logic              vec_rd,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              intr_ack,
    output logic              intr_active
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t            state;
    state_t            next_state;
    logic              int_prev;
    logic              pending;
    logic              start_drain;
    logic [CNT_W-1:0]  counter;
    logic [ADDR_W-1:0] save_pc_q;
    logic [ADDR_W-1:0] pc_target_q;

    assign start_drain = (state == IDLE) && pending && !pipe_busy;

    // State register; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: drain for a fixed count, then one cycle each of
    // save, vector fetch and entry; stay in the ISR until RTI retires.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_drain) next_state = DRAIN;
            DRAIN:   if (counter == '0) next_state = SAVE;
            SAVE:    next_state = VECTOR;
            VECTOR:  next_state = ENTER;
            ENTER:   next_state = ACTIVE;
            ACTIVE:  if (rti_retire) next_state = RESTORE;
            RESTORE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Edge detector and pending latch; a level present during reset is
    // absorbed into int_prev so it never looks like a fresh edge afterwards.
    // A new edge wins over the clear that happens on entry to DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_prev <= interrupt;
            pending  <= 1'b0;
        end else begin
            int_prev <= interrupt;
            if (interrupt && !int_prev) begin
                pending <= 1'b1;
            end else if (start_drain) begin
                pending <= 1'b0;
            end
        end
    end

    // Drain counter, return address capture (latest taken branch wins) and
    // ISR address capture from the vector read.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter     <= '0;
            save_pc_q   <= '0;
            pc_target_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_drain) begin
                        counter   <= DRAIN_LOAD;
                        save_pc_q <= branch_taken ? branch_target : pc_F;
                    end
                end
                DRAIN: begin
                    if (counter != '0) counter <= counter - 1'b1;
                    if (branch_taken) save_pc_q <= branch_target;
                end
                VECTOR: begin
                    pc_target_q <= ADDR_W'(mem_rdata);
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs decoded from state, forced low while reset is asserted.
    always_comb begin
        stall_F       = 1'b0;
        flush_D       = 1'b0;
        push_pc       = 1'b0;
        save_flags    = 1'b0;
        restore_flags = 1'b0;
        vec_rd        = 1'b0;
        pc_load       = 1'b0;
        intr_ack      = 1'b0;
        intr_active   = 1'b0;
        if (!reset) begin
            case (state)
                DRAIN: begin
                    stall_F     = 1'b1;
                    flush_D     = 1'b1;
                    intr_active = 1'b1;
                end
                SAVE: begin
                    stall_F     = 1'b1;
                    push_pc     = 1'b1;
                    save_flags  = 1'b1;
                    intr_active = 1'b1;
                end
                VECTOR: begin
                    stall_F     = 1'b1;
                    vec_rd      = 1'b1;
                    intr_active = 1'b1;
                end
                ENTER: begin
                    pc_load     = 1'b1;
                    intr_ack    = 1'b1;
                    intr_active = 1'b1;
                end
                ACTIVE: begin
                    intr_active = 1'b1;
                end
                RESTORE: begin
                    restore_flags = 1'b1;
                    intr_active   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign save_pc   = reset ? '0 : save_pc_q;
    assign pc_target = reset ? '0 : pc_target_q;

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a phase-count
// reference model.
module tb_intr_controller;

    localparam int D   = 3;
    localparam int ACT = D + 3;

    logic       clk;
    logic       reset;
    logic       interrupt;
    logic       pipe_busy;
    logic [7:0] pc_F;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] mem_rdata;
    logic       rti_retire;
    logic       stall_F;
    logic       flush_D;
    logic       push_pc;
    logic [7:0] save_pc;
    logic       save_flags;
    logic       restore_flags;
    logic       vec_rd;
    logic       pc_load;
    logic [7:0] pc_target;
    logic       intr_ack;
    logic       intr_active;

    intr_controller dut (
        .clk          (clk),
        .reset        (reset),
        .interrupt    (interrupt),
        .pipe_busy    (pipe_busy),
        .pc_F         (pc_F),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_rdata    (mem_rdata),
        .rti_retire   (rti_retire),
        .stall_F      (stall_F),
        .flush_D      (flush_D),
        .push_pc      (push_pc),
        .save_pc      (save_pc),
        .save_flags   (save_flags),
        .restore_flags(restore_flags),
        .vec_rd       (vec_rd),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .intr_ack     (intr_ack),
        .intr_active  (intr_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: m_phase is -1 when idle, otherwise cycles since the
    // start of service (0..D-1 drain, D save, D+1 vector, D+2 enter,
    // D+3 in ISR, D+4 restore).
    int         m_phase;
    logic       m_pend;
    logic       m_prev;
    logic [7:0] m_sp;
    logic [7:0] m_tgt;

    int         checks;
    int         passed;
    int         cyc;
    int         ack_count;
    int         load_count;
    int         stall_count;
    int         load_cycle;
    logic [7:0] pushed_pc;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected)
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, observed, expected);
        else
            passed++;
    endtask

    task automatic modelStep();
        logic edge_seen;
        logic enter;
        int   nxt;
        if (reset) begin
            m_phase = -1;
            m_pend  = 1'b0;
            m_prev  = interrupt;
            m_sp    = 8'h00;
            m_tgt   = 8'h00;
        end else begin
            edge_seen = interrupt && !m_prev;
            enter     = (m_phase == -1) && m_pend && !pipe_busy;
            if (m_phase == -1)         nxt = enter ? 0 : -1;
            else if (m_phase == ACT)   nxt = rti_retire ? ACT + 1 : ACT;
            else if (m_phase == ACT+1) nxt = -1;
            else                       nxt = m_phase + 1;
            if (enter)
                m_sp = branch_taken ? branch_target : pc_F;
            else if (m_phase >= 0 && m_phase < D && branch_taken)
                m_sp = branch_target;
            if (m_phase == D + 1) m_tgt = mem_rdata;
            if (edge_seen)  m_pend = 1'b1;
            else if (enter) m_pend = 1'b0;
            m_prev  = interrupt;
            m_phase = nxt;
        end
    endtask

    // One clock: inputs already set are sampled at the rising edge, the
    // model advances, and outputs are compared on the falling edge.
    task automatic applyStimulus();
        logic [8:0] exp_ctrl;
        logic [8:0] got_ctrl;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        cyc++;
        exp_ctrl = '0;
        if (!reset) begin
            exp_ctrl[8] = (m_phase >= 0) && (m_phase <= D + 1);
            exp_ctrl[7] = (m_phase >= 0) && (m_phase < D);
            exp_ctrl[6] = (m_phase == D);
            exp_ctrl[5] = (m_phase == D);
            exp_ctrl[4] = (m_phase == ACT + 1);
            exp_ctrl[3] = (m_phase == D + 1);
            exp_ctrl[2] = (m_phase == D + 2);
            exp_ctrl[1] = (m_phase == D + 2);
            exp_ctrl[0] = (m_phase >= 0);
        end
        got_ctrl = {stall_F, flush_D, push_pc, save_flags, restore_flags,
                    vec_rd, pc_load, intr_ack, intr_active};
        checkOutput("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
        checkOutput("save_pc", 32'(save_pc), reset ? 32'h0 : 32'(m_sp));
        checkOutput("pc_target", 32'(pc_target), reset ? 32'h0 : 32'(m_tgt));
        if (intr_ack) ack_count++;
        if (pc_load) begin
            load_count++;
            load_cycle = cyc;
        end
        if (push_pc) pushed_pc = save_pc;
        if (stall_F) stall_count++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic clearStats();
        ack_count   = 0;
        load_count  = 0;
        stall_count = 0;
        load_cycle  = -1;
        pushed_pc   = 8'h00;
    endtask

    int k0;

    initial begin
        checks = 0; passed = 0; cyc = 0;
        m_phase = -1; m_pend = 1'b0; m_prev = 1'b0; m_sp = '0; m_tgt = '0;
        clearStats();
        reset = 1'b1; interrupt = 1'b0; pipe_busy = 1'b0; pc_F = 8'h20;
        branch_taken = 1'b0; branch_target = 8'h00; mem_rdata = 8'h80; rti_retire = 1'b0;
        @(negedge clk);

        // Reset, with an interrupt rising inside the reset window.
        applyStimulus();
        interrupt = 1'b1;
        applyStimulus();
        reset = 1'b0;
        runCycles(4);
        interrupt = 1'b0;
        runCycles(2);
        checkOutput("reset_edge_dropped", 32'(ack_count), 32'd0);

        // Basic entry.
        clearStats();
        k0 = cyc; interrupt = 1'b1;
        applyStimulus();
        interrupt = 1'b0;
        runCycles(9);
        checkOutput("basic_latency", 32'(load_cycle - k0), 32'd7);
        checkOutput("basic_push_pc", 32'(pushed_pc), 32'h20);
        checkOutput("basic_ack_once", 32'(ack_count), 32'd1);
        rti_retire = 1'b1; applyStimulus(); rti_retire = 1'b0;
        runCycles(3);

        // Branch resolved in the second drain cycle.
        clearStats();
        k0 = cyc; interrupt = 1'b1;
        applyStimulus();
        interrupt = 1'b0;
        runCycles(2);
        branch_taken = 1'b1; branch_target = 8'h44;
        applyStimulus();
        branch_taken = 1'b0;
        runCycles(5);
        checkOutput("branch_push_pc", 32'(pushed_pc), 32'h44);
        rti_retire = 1'b1; applyStimulus(); rti_retire = 1'b0;
        runCycles(3);

        // pipe_busy defers entry by two cycles.
        clearStats();
        k0 = cyc; interrupt = 1'b1;
        applyStimulus();
        interrupt = 1'b0; pipe_busy = 1'b1;
        runCycles(2);
        pipe_busy = 1'b0;
        runCycles(8);
        checkOutput("busy_latency", 32'(load_cycle - k0), 32'd9);

        // Second edge while in the ISR is held off until after RTI.
        interrupt = 1'b1; applyStimulus(); interrupt = 1'b0;
        stall_count = 0;
        runCycles(5);
        checkOutput("masked_no_stall", 32'(stall_count), 32'd0);
        k0 = cyc; rti_retire = 1'b1;
        applyStimulus();
        rti_retire = 1'b0;
        runCycles(9);
        checkOutput("nested_latency", 32'(load_cycle - k0), 32'd8);
        checkOutput("nested_acks", 32'(ack_count), 32'd2);
        rti_retire = 1'b1; applyStimulus(); rti_retire = 1'b0;
        runCycles(3);

        // Level held high for 50 cycles gives exactly one service.
        clearStats();
        interrupt = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rti_retire = (i == 20);
            applyStimulus();
        end
        interrupt = 1'b0; rti_retire = 1'b0;
        runCycles(3);
        checkOutput("level_one_ack", 32'(ack_count), 32'd1);

        // Reset while fetching the vector: no entry for that interrupt.
        clearStats();
        interrupt = 1'b1; applyStimulus(); interrupt = 1'b0;
        runCycles(5);
        reset = 1'b1; applyStimulus(); reset = 1'b0;
        runCycles(10);
        checkOutput("reset_vector_no_load", 32'(load_count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 5) == 0) interrupt = ~interrupt;
            pipe_busy     = ($urandom_range(0, 2) == 0);
            pc_F          = 8'($urandom);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = 8'($urandom);
            mem_rdata     = 8'($urandom);
            rti_retire    = ($urandom_range(0, 9) == 0);
            applyStimulus();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/intr_controller.md
Name: intr_controller

Overview:
Interrupt sequencer for the 8-bit pipelined CPU, sitting beside the decode stage and driving fetch/decode control.
- Latches the external interrupt pin and waits for a safe instruction boundary.
- Drains the pipeline, saves PC and flags, and redirects fetch to the vector held in unified memory.
- Masks further service until RTI retires, then restores flags.

Parameters:
ADDR_W, 8, width of PC and memory address.
VECTOR_ADDR, 8'h01, memory address holding the ISR start address.
DRAIN_CYCLES, 3, cycles of fetch-stall/decode-flush so that ID, EX and MEM empty before the save.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
interrupt  in  1  external interrupt pin, already synchronous to clk.
pipe_busy  in  1  decode holds the first byte of a two-byte instruction, or a branch is unresolved; entry is deferred.
pc_F  in  ADDR_W  current fetch PC.
branch_taken  in  1  EX resolved a taken branch this cycle.
branch_target  in  ADDR_W  EX branch target.
mem_rdata  in  8  data-port read data (combinational, same cycle as vec_rd).
rti_retire  in  1  an RTI is in EX this cycle.
stall_F  out  1  hold PC.
flush_D  out  1  inject a bubble into IF/ID.
push_pc  out  1  one-cycle request to push save_pc onto the stack.
save_pc  out  ADDR_W  return address to push.
save_flags  out  1  one-cycle pulse: EX copies flags into its preserved-flags register.
restore_flags  out  1  one-cycle pulse: EX restores the preserved flags.
vec_rd  out  1  data-port read of VECTOR_ADDR.
pc_load  out  1  one-cycle pulse: fetch loads pc_target.
pc_target  out  ADDR_W  ISR entry address.
intr_ack  out  1  one-cycle pulse when the ISR is entered.
intr_active  out  1  high from DRAIN entry until RESTORE completes.

Behaviour:
Reset:
- On reset high at a clock edge: state=IDLE; pending, counter, save_pc and pc_target cleared.
- All outputs are 0 during and after reset.
- An interrupt edge in the reset cycle is dropped.

Pending latch:
- Set on a rising edge of interrupt (registered previous sample; 0→1).
- Cleared when entering DRAIN.
- A level held high produces exactly one service.

FSM (Moore outputs, registered state):
- IDLE: stall_F=0, flush_D=0. If pending && !pipe_busy → DRAIN. On that edge: save_pc<=pc_F, counter<=DRAIN_CYCLES-1. If branch_taken in the same cycle, save_pc<=branch_target.
- DRAIN: stall_F=1, flush_D=1, intr_active=1. Counter decrements each cycle. If branch_taken, save_pc<=branch_target (the latest wins). When counter==0 → SAVE.
- SAVE: one cycle. push_pc=1, save_flags=1, stall_F=1 → VECTOR.
- VECTOR: one cycle. vec_rd=1, stall_F=1. pc_target<=mem_rdata → ENTER.
- ENTER: one cycle. pc_load=1, intr_ack=1, stall_F=0 → ACTIVE.
- ACTIVE: intr_active=1, no stall. New edges set pending but are not serviced. rti_retire → RESTORE.
- RESTORE: one cycle. restore_flags=1 → IDLE. A pending interrupt is serviced no earlier than the next IDLE evaluation, i.e. at least one IDLE cycle between services.

Latency and concurrency:
- Latency from interrupt edge (with pipe_busy=0) to pc_load is 1 + DRAIN_CYCLES + 3 cycles.
- rti_retire outside ACTIVE is ignored.
- pipe_busy is only sampled in IDLE.
- Reset has priority over every transition, in every state.

Decomposition:
- Shared package: state encoding (IDLE, DRAIN, SAVE, VECTOR, ENTER, ACTIVE, RESTORE as 3-bit localparams), VECTOR_ADDR default, ADDR_W.
- No sub-module needed; the edge detector stays inline as two registers.

Test Plan:
- Basic entry: pc_F=8'h20, M[1]=8'h80, single-cycle interrupt pulse → stall_F high 3 cycles then SAVE with push_pc=1 and save_pc=8'h20; pc_load=1 with pc_target=8'h80 exactly 7 cycles after the edge; intr_ack pulses once.
- Branch during drain: branch_taken=1 with branch_target=8'h44 in the 2nd DRAIN cycle → push_pc carries save_pc=8'h44.
- pipe_busy deferral: interrupt while pipe_busy=1 for 2 cycles → DRAIN entered on the first cycle with pipe_busy=0; pending stays set meanwhile.
- Masked nesting: second interrupt edge during ACTIVE → no stall until rti_retire. Then restore_flags pulses, one IDLE cycle follows, and a second full entry sequence runs.
- Level hold: interrupt held high for 50 cycles → exactly one intr_ack.
- Reset mid-operation: reset asserted in VECTOR → next cycle all outputs 0 and state IDLE; no pc_load ever issued for that interrupt.
